// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the shared radix-2 Booth multiplier.
package booth_mul_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Booth recoding of the bit pair {X[i], X[i-1]}
    localparam logic [1:0] BoothNop0 = 2'b00;
    localparam logic [1:0] BoothAdd  = 2'b01;
    localparam logic [1:0] BoothSub  = 2'b10;
    localparam logic [1:0] BoothNop1 = 2'b11;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/booth_seq_core.sv
// Iterative radix-2 Booth datapath: one recode/add/shift step per step_i pulse.
module booth_seq_core
    import booth_mul_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    output logic [2*W-1:0]   product_o,
    output logic             last_o
);

    localparam int unsigned CntW = (clog2(W) > 0) ? clog2(W) : 1;

    logic [W:0]      hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            xm1_q, xm1_d;
    logic [W:0]      b_q, b_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W:0]      sum;

    // b_q is one bit wider than the operand so negating the most negative value is exact
    always_comb begin
        unique case ({lo_q[0], xm1_q})
            BoothSub: sum = hi_q - b_q;
            BoothAdd: sum = hi_q + b_q;
            default:  sum = hi_q;
        endcase
    end

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        xm1_d = xm1_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        if (load_i) begin
            hi_d  = '0;
            lo_d  = a_i;
            xm1_d = 1'b0;
            b_d   = {b_i[W-1], b_i};
            cnt_d = '0;
        end else if (step_i) begin
            hi_d  = {sum[W], sum[W:1]};
            lo_d  = {sum[0], lo_q[W-1:1]};
            xm1_d = lo_q[0];
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hi_q  <= '0;
            lo_q  <= '0;
            xm1_q <= 1'b0;
            b_q   <= '0;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            xm1_q <= xm1_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
        end
    end

    // Post-shift value of the current step; valid as the final product when last_o is high
    assign product_o = {sum, lo_q[W-1:1]};
    assign last_o    = step_i && (cnt_q == CntW'(W - 1));

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin front end sharing one Booth multiplier engine among N requesters.
module booth_mul_arbiter
    import booth_mul_pkg::*;
#(
    parameter int unsigned W   = 4,
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = clog2(N)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N-1:0]       req_valid_i,
    output logic [N-1:0]       req_ready_o,
    input  logic [N*W-1:0]     req_a_i,
    input  logic [N*W-1:0]     req_b_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [2*W-1:0]     rsp_z_o,
    output logic [IDW-1:0]     rsp_id_o,
    output logic               busy_o
);

    state_e           state_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   owner_q;
    logic             rsp_valid_q;
    logic [2*W-1:0]   rsp_z_q;
    logic [IDW-1:0]   rsp_id_q;
    logic             busy_q;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW:0]     scan_sum;
    logic [IDW-1:0]   scan_idx;
    logic [IDW-1:0]   rr_next;
    logic [W-1:0]     a_sel;
    logic [W-1:0]     b_sel;
    logic             handshake;
    logic [2*W-1:0]   core_product;
    logic             core_last;

    // First valid requester at or after rr_ptr, wrapping at N
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (IDW + 1)'(k);
            if (scan_sum >= (IDW + 1)'(N)) begin
                scan_sum = scan_sum - (IDW + 1)'(N);
            end
            scan_idx = scan_sum[IDW-1:0];
            if (!grant_found && req_valid_i[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_idx == IDW'(i)) begin
                a_sel = req_a_i[i*W +: W];
                b_sel = req_b_i[i*W +: W];
            end
        end
    end

    // Gated by reset so nothing is offered while the block is held in reset
    assign handshake = (state_q == StIdle) && grant_found && !rst_i;
    assign rr_next   = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        req_ready_o = '0;
        if (handshake) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    booth_seq_core #(
        .W (W)
    ) u_core (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (handshake),
        .step_i    (state_q == StRun),
        .a_i       (a_sel),
        .b_i       (b_sel),
        .product_o (core_product),
        .last_o    (core_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_z_q     <= '0;
            rsp_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (handshake) begin
                        owner_q  <= grant_idx;
                        rr_ptr_q <= rr_next;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    if (core_last) begin
                        rsp_z_q     <= core_product;
                        rsp_id_q    <= owner_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_z_o     = rsp_z_q;
    assign rsp_id_o    = rsp_id_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter: directed vectors plus an exhaustive operand sweep.
module tb_booth_mul_arbiter;

    localparam int W   = 4;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*W-1:0]     req_a;
    logic [N*W-1:0]     req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [2*W-1:0]     rsp_z;
    logic [IDW-1:0]     rsp_id;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hs_cyc   = 0;
    int rise_cyc = 0;
    logic prev_v = 1'b0;
    logic [N-1:0] last_hs = '0;
    bit rand_rdy = 1'b0;

    logic [IDW+2*W-1:0] exp_q[$];
    logic [IDW+2*W-1:0] mon_e;

    booth_mul_arbiter #(
        .W   (W),
        .N   (N),
        .IDW (IDW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_z_o     (rsp_z),
        .rsp_id_o    (rsp_id),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every accepted response is popped and compared against the scoreboard
    always @(negedge clk) begin
        if (rsp_valid === 1'b1 && prev_v !== 1'b1) rise_cyc <= cyc;
        prev_v <= rsp_valid;
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id %0d z %0h, required no response", rsp_id, rsp_z);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_z", 32'(rsp_z), 32'(mon_e[2*W-1:0]));
                chk("rsp_id", 32'(rsp_id), 32'(mon_e[IDW+2*W-1:2*W]));
            end
        end
    end

    // One clock: record handshakes, then requesters drop valid once accepted
    task automatic cycle();
        @(negedge clk);
        last_hs = req_valid & req_ready;
        if (last_hs != '0) hs_cyc = cyc;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~last_hs;
        if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic set_op(input int p, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[p*W +: W] = a;
        req_b[p*W +: W] = b;
    endtask

    task automatic issue(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] z, input bit push);
        int n;
        n = 0;
        while (req_valid != '0 && n < 100) begin
            cycle();
            n++;
        end
        chk("issue_wait", 32'(req_valid != '0), 32'd0);
        set_op(p, a, b);
        req_valid[p] = 1'b1;
        if (push) exp_q.push_back({IDW'(p), z});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || req_valid != '0) && n < budget) begin
            cycle();
            n++;
        end
        chk(name, 32'(exp_q.size()) + 32'(req_valid != '0), 32'd0);
    endtask

    task automatic wait_rsp_valid(input string name);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 30) begin
            cycle();
            n++;
        end
        chk(name, 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit re_done;
        int n;
        int sa;
        int sb;
        logic [W-1:0] a4;
        logic [W-1:0] b4;
        logic [2*W-1:0] p8;

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // All four requesters valid from reset; port 0 re-requests right after its grant
        for (int i = 0; i < N; i++) begin
            set_op(i, W'(i + 1), W'(2));
            exp_q.push_back({IDW'(i), 8'(2 * (i + 1))});
        end
        exp_q.push_back({IDW'(0), 8'h0F});
        req_valid = '1;
        cycle();
        cycle();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_z", 32'(rsp_z), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("first_grant_port0", 32'(req_ready), 32'b0001);
        re_done = 1'b0;
        n = 0;
        while ((req_valid != '0 || !re_done) && n < 200) begin
            cycle();
            if (last_hs[0] && !re_done) begin
                re_done = 1'b1;
                set_op(0, 4'd5, 4'd3);
                req_valid[0] = 1'b1;
            end
            n++;
        end
        wait_drain("drain_rr", 200);

        // Single request: 3 * -2, with latency measured from the handshake cycle
        issue(0, 4'd3, 4'hE, 8'hFA, 1'b1);
        #1;
        chk("t1_ready", 32'(req_ready), 32'b0001);
        wait_drain("drain_t1", 50);
        chk("t1_latency", 32'(rise_cyc - hs_cyc), 32'd5);

        // Most-negative operand corners
        issue(1, 4'h8, 4'h8, 8'h40, 1'b1);
        issue(2, 4'h7, 4'h8, 8'hC8, 1'b1);
        issue(3, 4'h8, 4'h0, 8'h00, 1'b1);
        wait_drain("drain_corner", 100);

        // Back-pressure: result held in DONE while another requester waits
        rsp_ready = 1'b0;
        issue(2, 4'hD, 4'h5, 8'hF1, 1'b1);
        wait_rsp_valid("t4_rsp_valid_rise");
        issue(3, 4'd2, 4'd2, 8'h04, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
            chk("t4_hold_z", 32'(rsp_z), 32'hF1);
            chk("t4_hold_id", 32'(rsp_id), 32'd2);
            chk("t4_hold_ready", 32'(req_ready), 32'd0);
            chk("t4_hold_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        cycle();
        chk("t4_release_busy", 32'(busy), 32'd0);
        chk("t4_release_valid", 32'(rsp_valid), 32'd0);
        chk("t4_release_grant3", 32'(req_ready), 32'b1000);
        wait_drain("drain_t4", 50);

        // Reset two cycles into RUN; the in-flight product must never appear
        issue(1, 4'd3, 4'd3, 8'h09, 1'b0);
        n = 0;
        while (!last_hs[1] && n < 20) begin
            cycle();
            n++;
        end
        chk("t5_accepted", 32'(last_hs[1]), 32'd1);
        cycle();
        #2;
        chk("t5_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_valid", 32'(rsp_valid), 32'd0);
        cycle();
        cycle();
        rst = 1'b0;
        set_op(0, 4'hF, 4'hF);
        set_op(3, 4'h9, 4'h3);
        req_valid = 4'b1001;
        exp_q.push_back({IDW'(0), 8'h01});
        exp_q.push_back({IDW'(3), 8'hEB});
        #1;
        chk("t5_rr_ptr_reset", 32'(req_ready), 32'b0001);
        wait_drain("drain_t5", 100);

        // Reset while a result is waiting in DONE
        rsp_ready = 1'b0;
        issue(2, 4'd5, 4'd5, 8'h19, 1'b0);
        wait_rsp_valid("t5b_rsp_valid_rise");
        #2;
        rst = 1'b1;
        #1;
        chk("t5b_async_valid", 32'(rsp_valid), 32'd0);
        chk("t5b_async_z", 32'(rsp_z), 32'd0);
        chk("t5b_async_id", 32'(rsp_id), 32'd0);
        chk("t5b_async_busy", 32'(busy), 32'd0);
        cycle();
        rst = 1'b0;
        rsp_ready = 1'b1;

        // Every operand pair, rotating ports, random consumer back-pressure
        rand_rdy = 1'b1;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                a4 = W'(ai);
                b4 = W'(bi);
                sa = $signed(a4);
                sb = $signed(b4);
                p8 = 8'(sa * sb);
                issue((ai * 16 + bi) % N, a4, b4, p8, 1'b1);
            end
        end
        wait_drain("drain_sweep", 3000);
        rand_rdy  = 1'b0;
        rsp_ready = 1'b1;
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
